// File: rtl/raw10_unpack_if.sv
// Stream bundle for raw10_unpack: CSI-2 lane words in, pixel pairs and line status out.
interface raw10_unpack_if;
  logic [15:0] in_data;
  logic        in_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_line_done;
  logic        err_len;
  logic        err_partial;

  modport master (
    output in_data, in_valid,
    input  out_data, out_valid, out_line_done, err_len, err_partial
  );

  modport slave (
    input  in_data, in_valid,
    output out_data, out_valid, out_line_done, err_len, err_partial
  );
endinterface

// File: rtl/raw10_unpack.sv
// RAW10 2-lane unpacker: 5-byte groups -> two 8-bit pixel-pair words, with line length checking.
// Define RAW10_ROUND_EN for round-half-up 10->8 bit conversion with saturation (default truncates).
module raw10_unpack #(
  parameter int LINE_LENGTH = 640,
  parameter int CNT_WIDTH   = $clog2(LINE_LENGTH/2+1)
) (
  input logic          clk,
  input logic          rst,
  raw10_unpack_if.slave bus
);

`ifdef RAW10_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  localparam int                   WPL   = LINE_LENGTH / 2;
  localparam logic [CNT_WIDTH-1:0] WPL_C = CNT_WIDTH'(WPL);

  typedef enum logic [1:0] {IDLE, LINE, DRAIN} state_t;

  state_t               state;
  logic [3:0][7:0]      acc;
  logic [2:0]           acc_cnt;
  logic [15:0]          pend;
  logic                 pend_v;
  logic [CNT_WIDTH-1:0] word_cnt;
  logic                 overlong;

  logic                 take;
  logic [5:0][7:0]      tmp;
  logic [2:0]           tmp_cnt;
  logic                 grp;
  logic [3:0][7:0]      pix;
  logic                 emit;
  logic [15:0]          emit_word;
  logic                 keep;
  logic                 ovl_n;
  logic                 drain_n;
  logic                 done_n;

  // (P + 2) >> 2 with saturation; with rounding disabled this reduces to P[9:2].
  function automatic logic [7:0] to8(input logic [9:0] p);
    logic [8:0] s;
    s = 9'((11'(p) + (ROUND_EN ? 11'd2 : 11'd0)) >> 2);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  always_comb begin
    take    = bus.in_valid && (state != DRAIN);
    tmp     = {16'h0, acc};
    tmp_cnt = acc_cnt;
    // Bytes above acc_cnt are kept zero, so the append is a plain shifted OR.
    if (take) begin
      tmp     = tmp | ({32'h0, bus.in_data} << {acc_cnt, 3'b000});
      tmp_cnt = acc_cnt + 3'd2;
    end
    grp       = (tmp_cnt >= 3'd5);
    pix[0]    = to8({tmp[0], tmp[4][1:0]});
    pix[1]    = to8({tmp[1], tmp[4][3:2]});
    pix[2]    = to8({tmp[2], tmp[4][5:4]});
    pix[3]    = to8({tmp[3], tmp[4][7:6]});
    emit      = grp || pend_v;
    emit_word = grp ? {pix[1], pix[0]} : pend;
    keep      = emit && (word_cnt < WPL_C);
    ovl_n     = overlong || (emit && !keep);
    drain_n   = ((state == LINE) && !bus.in_valid) || ((state == DRAIN) && !bus.out_line_done);
    done_n    = drain_n && !keep;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      acc               <= '0;
      acc_cnt           <= '0;
      pend              <= '0;
      pend_v            <= 1'b0;
      word_cnt          <= '0;
      overlong          <= 1'b0;
      bus.out_data      <= '0;
      bus.out_valid     <= 1'b0;
      bus.out_line_done <= 1'b0;
      bus.err_len       <= 1'b0;
      bus.err_partial   <= 1'b0;
    end else begin
      bus.out_valid <= keep;
      if (keep) begin
        bus.out_data <= emit_word;
        word_cnt     <= word_cnt + CNT_WIDTH'(1);
      end
      overlong <= ovl_n;
      if (take) begin
        acc_cnt <= grp ? tmp_cnt - 3'd5 : tmp_cnt;
        acc     <= grp ? {24'h0, tmp[5]} : tmp[3:0];
      end
      pend_v <= grp;
      if (grp) pend <= {pix[3], pix[2]};
      // Done is predicted one edge early so it lands in the first empty DRAIN cycle.
      bus.out_line_done <= done_n;
      bus.err_len       <= done_n && ((word_cnt != WPL_C) || ovl_n);
      bus.err_partial   <= done_n && (acc_cnt != 3'd0);
      case (state)
        IDLE:    if (bus.in_valid) state <= LINE;
        LINE:    if (!bus.in_valid) state <= DRAIN;
        DRAIN: begin
          if (bus.out_line_done) begin
            state    <= IDLE;
            acc      <= '0;
            acc_cnt  <= '0;
            pend_v   <= 1'b0;
            word_cnt <= '0;
            overlong <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
